uart_frame_parser: RTL and testbench

- Downstream consumer of the UART receiver. Takes its byte stream: rx_data/valid plus the check (parity error) and stop (stop-bit error) flags.
- Assembles framed packets in the format HEAD0 HEAD1 LEN PAYLOAD[LEN] SUM.
- Stores the payload in an internal byte buffer and reports frame completion or a typed error to the control logic.

---
 rtl/uart_frame_parser.sv | 162 ++++++++++++++++
 tb/tb_uart_frame_parser.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: turns the UART receiver's byte stream into framed packets of the
// form HEAD0 HEAD1 LEN PAYLOAD[LEN] SUM. The payload goes into a byte buffer that the
// control logic can read, and the block pulses either frame_done or a typed frame_err.
module uart_frame_parser #(
    parameter logic [7:0] HEAD0       = 8'hEB,
    parameter logic [7:0] HEAD1       = 8'h90,
    parameter int         MAX_LEN     = 16,
    parameter int         ADDR_W      = 4,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_check,
    input  logic              rx_stop,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [7:0]        frame_len,
    output logic              frame_done,
    output logic              frame_err,
    output logic [2:0]        err_code,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HEAD1 = 3'd1,
        S_LEN   = 3'd2,
        S_DATA  = 3'd3,
        S_SUM   = 3'd4
    } state_t;

    localparam logic [2:0]  ERR_LINE  = 3'd1;
    localparam logic [2:0]  ERR_LEN   = 3'd2;
    localparam logic [2:0]  ERR_SUM   = 3'd3;
    localparam logic [2:0]  ERR_TMO   = 3'd4;
    localparam logic [8:0]  MAX_LEN_9 = 9'(MAX_LEN);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYC - 1);

    state_t              state_q;
    logic [7:0]          len_q;
    logic [7:0]          sum_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [15:0]         tmo_q;
    logic [7:0]          frame_len_q;
    logic                done_q;
    logic                err_q;
    logic [2:0]          code_q;
    logic [7:0]          rd_data_q;
    logic [7:0]          mem [2**ADDR_W];

    logic                line_err;
    logic                wr_en;

    assign line_err = rx_check | rx_stop;
    // A payload byte is stored only when it is not going to abort the frame.
    assign wr_en    = rx_valid && (state_q == S_DATA) && !line_err;

    // Frame parser: header hunt, length check, payload accumulation, checksum and timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            frame_len_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            // Inter-byte silence counter; any byte restarts it, idle holds it at zero.
            if (state_q == S_IDLE || rx_valid) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 16'd1;
            end

            if (rx_valid) begin
                case (state_q)
                    S_IDLE: begin
                        if (!line_err && rx_data == HEAD0) state_q <= S_HEAD1;
                    end
                    S_HEAD1: begin
                        if (line_err)               state_q <= S_IDLE;
                        else if (rx_data == HEAD1)  state_q <= S_LEN;
                        else if (rx_data == HEAD0)  state_q <= S_HEAD1;
                        else                        state_q <= S_IDLE;
                    end
                    S_LEN: begin
                        if (line_err) begin
                            state_q <= S_IDLE;
                            err_q   <= 1'b1;
                            code_q  <= ERR_LINE;
                        end else if (rx_data == 8'd0 || {1'b0, rx_data} > MAX_LEN_9) begin
                            state_q <= S_IDLE;
                            err_q   <= 1'b1;
                            code_q  <= ERR_LEN;
                        end else begin
                            len_q   <= rx_data;
                            sum_q   <= rx_data;
                            idx_q   <= '0;
                            state_q <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (line_err) begin
                            state_q <= S_IDLE;
                            err_q   <= 1'b1;
                            code_q  <= ERR_LINE;
                        end else begin
                            sum_q <= sum_q + rx_data;
                            idx_q <= idx_q + ADDR_W'(1);
                            if (8'(idx_q) == len_q - 8'd1) state_q <= S_SUM;
                        end
                    end
                    S_SUM: begin
                        state_q <= S_IDLE;
                        if (line_err) begin
                            err_q  <= 1'b1;
                            code_q <= ERR_LINE;
                        end else if (rx_data == sum_q) begin
                            done_q      <= 1'b1;
                            frame_len_q <= len_q;
                        end else begin
                            err_q  <= 1'b1;
                            code_q <= ERR_SUM;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (state_q != S_IDLE && tmo_q == TMO_LAST) begin
                state_q <= S_IDLE;
                err_q   <= 1'b1;
                code_q  <= ERR_TMO;
            end
        end
    end

    // Payload buffer write port; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[idx_q] <= rx_data;
    end

    // Registered read port; a same-cycle write to rd_addr returns the previous byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= mem[rd_addr];
    end

    assign rd_data    = rd_data_q;
    assign frame_len  = frame_len_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign err_code   = code_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: directed test-plan sequences followed by random frames,
// checked every cycle against a queue-based reference model of the framing rules.
module tb_uart_frame_parser;

    localparam int TO  = 100;
    localparam int MAXL = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_check = 1'b0;
    logic       rx_stop = 1'b0;
    logic [3:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic [7:0] frame_len;
    logic       frame_done;
    logic       frame_err;
    logic [2:0] err_code;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    uart_frame_parser #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_check(rx_check), .rx_stop(rx_stop), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_len(frame_len), .frame_done(frame_done), .frame_err(frame_err),
        .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: m_n = number of frame bytes accepted so far (0 = hunting),
    // payload kept in a queue, checksum recomputed from the queue at the end.
    int         m_n = 0;
    int         m_len = 0;
    int         m_quiet = 0;
    logic [7:0] m_pay[$];
    logic [7:0] m_buf[MAXL];
    logic [7:0] m_flen = 0;
    logic [2:0] m_code = 0;
    bit         m_done = 0;
    bit         m_err = 0;

    task automatic m_abort(input logic [2:0] c);
        m_err = 1; m_code = c; m_n = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit le);
        int s;
        m_done = 0; m_err = 0;
        if (!v) begin
            if (m_n > 0) begin
                m_quiet++;
                if (m_quiet == TO) m_abort(3'd4);
            end
        end else begin
            m_quiet = 0;
            if (m_n == 0) begin
                if (!le && d == 8'hEB) m_n = 1;
            end else if (m_n == 1) begin
                if (le) m_n = 0;
                else if (d == 8'h90) m_n = 2;
                else if (d == 8'hEB) m_n = 1;
                else m_n = 0;
            end else if (le) begin
                m_abort(3'd1);
            end else if (m_n == 2) begin
                if (d == 0 || d > MAXL) m_abort(3'd2);
                else begin m_len = d; m_pay.delete(); m_n = 3; end
            end else if (m_pay.size() < m_len) begin
                m_pay.push_back(d); m_n++;
            end else begin
                s = m_len;
                foreach (m_pay[i]) s += m_pay[i];
                if (d == 8'(s % 256)) begin
                    m_done = 1; m_flen = 8'(m_len); m_n = 0;
                    foreach (m_pay[i]) m_buf[i] = m_pay[i];
                end else m_abort(3'd3);
            end
        end
        if (m_n == 0) m_quiet = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit v, input logic [7:0] d, input bit ck, input bit st);
        @(negedge clk);
        rx_valid = v; rx_data = d; rx_check = ck; rx_stop = st;
        @(posedge clk);
        model_step(v, d, ck | st);
        #1;
        chk("frame_done", 32'(frame_done), 32'(m_done));
        chk("frame_err", 32'(frame_err), 32'(m_err));
        chk("err_code", 32'(err_code), 32'(m_code));
        chk("frame_len", 32'(frame_len), 32'(m_flen));
        chk("busy", 32'(busy), 32'(m_n > 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 8'($urandom), 0, 0);
    endtask

    task automatic send(input logic [7:0] b);
        tick(1, b, 0, 0);
    endtask

    task automatic read_check(input int a);
        @(negedge clk);
        rd_addr = 4'(a);
        tick(0, 8'h00, 0, 0);
        chk($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(m_buf[a]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; rx_valid = 0;
        #1;
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_frame_len", 32'(frame_len), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_err", 32'(frame_err), 0);
        chk("rst_code", 32'(err_code), 0);
        chk("rst_busy", 32'(busy), 0);
        m_n = 0; m_quiet = 0; m_flen = 0; m_code = 0; m_pay.delete();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        logic [7:0] q[$];
        int k;
        int kind;
        int len;
        int cut;
        int s;
        logic [7:0] b;

        do_reset();

        // Good frame and buffer read-back.
        q = '{8'hEB, 8'h90, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        foreach (q[i]) send(q[i]);
        chk("good_done", 32'(frame_done), 1);
        for (int a = 0; a < 3; a++) read_check(a);
        chk("good_rd2", 32'(rd_data), 32'h33);

        // Bad checksum keeps the previous frame_len.
        q = '{8'hEB, 8'h90, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68};
        foreach (q[i]) send(q[i]);
        chk("sum_code", 32'(err_code), 3);
        chk("sum_len_kept", 32'(frame_len), 3);

        // Bad lengths.
        send(8'hEB); send(8'h90); send(8'h00);
        chk("len0_code", 32'(err_code), 2);
        idle(2);
        send(8'hEB); send(8'h90); send(8'h11);
        chk("len17_code", 32'(err_code), 2);

        // Line error inside a frame, then in idle.
        send(8'hEB); send(8'h90); send(8'h02); tick(1, 8'hAA, 1, 0);
        chk("line_code", 32'(err_code), 1);
        tick(1, 8'hAA, 1, 0);
        chk("line_idle_err", 32'(frame_err), 0);

        // Timeout after silence.
        q = '{8'hEB, 8'h90, 8'h04, 8'h01, 8'h02};
        foreach (q[i]) send(q[i]);
        k = 0;
        do begin tick(0, 8'h00, 0, 0); k++; end while (!frame_err && k < 200);
        chk("tmo_latency", 32'(k), TO);
        chk("tmo_code", 32'(err_code), 4);

        // Byte arriving exactly at expiry keeps the frame alive.
        send(8'hEB); send(8'h90); send(8'h04); send(8'h01);
        idle(TO - 1);
        send(8'h02); send(8'h03); send(8'h04); send(8'h0E);
        chk("expiry_done", 32'(frame_done), 1);

        // Header resync and checksum wrap.
        q = '{8'hEB, 8'hEB, 8'h90, 8'h02, 8'hFF, 8'hFF, 8'h00};
        foreach (q[i]) send(q[i]);
        chk("wrap_done", 32'(frame_done), 1);
        chk("wrap_len", 32'(frame_len), 2);

        // Reset mid-payload, then a good frame.
        send(8'hEB); send(8'h90); send(8'h04); send(8'h01); send(8'h02);
        do_reset();
        q = '{8'hEB, 8'h90, 8'h01, 8'h5A, 8'h5B};
        foreach (q[i]) send(q[i]);
        chk("post_rst_done", 32'(frame_done), 1);
        read_check(0);

        // Random frames: good, bad sum, line error, bad length, timeout, leading junk.
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            len = $urandom_range(1, MAXL);
            q = '{8'hEB, 8'h90, 8'(len)};
            s = len;
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                q.push_back(b);
                s += b;
            end
            q.push_back(8'(s % 256));
            if (kind == 4) begin
                b = 8'($urandom_range(0, 8'hEA));
                send(b);
            end
            cut = q.size();
            if (kind == 0) q[q.size() - 1] = q[q.size() - 1] ^ 8'(1 << $urandom_range(0, 7));
            if (kind == 2) begin q[2] = 8'($urandom_range(MAXL + 1, 255)); cut = 3; end
            if (kind == 1 || kind == 3) cut = $urandom_range(1, q.size() - 1);
            for (int i = 0; i < cut; i++) begin
                if (kind == 1 && i == cut - 1) tick(1, q[i], 0, 1);
                else send(q[i]);
                idle($urandom_range(0, 2));
            end
            if (kind == 1 && cut >= 3) chk("rnd_line_code", 32'(err_code), 1);
            if (kind == 3) idle(TO + 5);
            if (kind >= 4) for (int r = 0; r < 2; r++) read_check($urandom_range(0, len - 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
